// File: rtl/spu_writeback.sv
// spu_writeback: dual-pipe latency-tagged result writeback scheduler with RAW/WAW hazard tracking
module spu_writeback #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 7,
    parameter int MAX_LAT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_e,
    input  logic              in_valid_o,
    input  logic [ADDR_W-1:0] in_addr_e,
    input  logic [ADDR_W-1:0] in_addr_o,
    input  logic [DATA_W-1:0] in_data_e,
    input  logic [DATA_W-1:0] in_data_o,
    input  logic [2:0]        in_lat_e,
    input  logic [2:0]        in_lat_o,
    input  logic              flush,
    input  logic [ADDR_W-1:0] q_addr_a,
    input  logic [ADDR_W-1:0] q_addr_b,
    output logic              q_hit_a,
    output logic              q_hit_b,
    output logic              rt_we_e,
    output logic              rt_we_o,
    output logic [ADDR_W-1:0] rt_addr_e,
    output logic [ADDR_W-1:0] rt_addr_o,
    output logic [DATA_W-1:0] rt_data_e,
    output logic [DATA_W-1:0] rt_data_o,
    output logic              coll_err,
    output logic              waw_err
);
    // Slot MAX_LAT is a permanently empty pad so the top slot shifts in zeros and never collides.
    logic              v_q [2][MAX_LAT+1];
    logic              v_d [2][MAX_LAT+1];
    logic [ADDR_W-1:0] a_q [2][MAX_LAT+1];
    logic [ADDR_W-1:0] a_d [2][MAX_LAT+1];
    logic [DATA_W-1:0] d_q [2][MAX_LAT+1];
    logic [DATA_W-1:0] d_d [2][MAX_LAT+1];
    logic              coll_q, coll_d, waw_q, waw_d, waw, bad;
    logic              iv [2];
    logic [ADDR_W-1:0] ia [2];
    logic [DATA_W-1:0] id [2];
    logic [2:0]        il [2];

    assign iv[0] = in_valid_e;
    assign iv[1] = in_valid_o;
    assign ia[0] = in_addr_e;
    assign ia[1] = in_addr_o;
    assign id[0] = in_data_e;
    assign id[1] = in_data_o;
    assign il[0] = in_lat_e;
    assign il[1] = in_lat_o;

    assign waw = v_q[0][0] && v_q[1][0] && a_q[0][0] == a_q[1][0];

    always_comb begin
        coll_d = coll_q;
        waw_d  = waw_q | waw;
        bad    = 1'b0;
        for (int p = 0; p < 2; p++) begin
            // Stays set unless some slot legally takes the entry.
            bad = iv[p] && !flush;
            for (int k = 0; k < MAX_LAT; k++) begin
                v_d[p][k] = v_q[p][k+1] && !flush;
                a_d[p][k] = flush ? '0 : a_q[p][k+1];
                d_d[p][k] = flush ? '0 : d_q[p][k+1];
                if (iv[p] && !flush && il[p] == 3'(k + 1)) begin
                    bad = v_q[p][k+1];
                    if (!v_q[p][k+1]) begin
                        v_d[p][k] = 1'b1;
                        a_d[p][k] = ia[p];
                        d_d[p][k] = id[p];
                    end
                end
            end
            v_d[p][MAX_LAT] = 1'b0;
            a_d[p][MAX_LAT] = '0;
            d_d[p][MAX_LAT] = '0;
            coll_d = coll_d | bad;
        end
    end

    always_comb begin
        q_hit_a = 1'b0;
        q_hit_b = 1'b0;
        for (int p = 0; p < 2; p++) begin
            q_hit_a = q_hit_a | (iv[p] && !flush && ia[p] == q_addr_a);
            q_hit_b = q_hit_b | (iv[p] && !flush && ia[p] == q_addr_b);
            for (int k = 0; k < MAX_LAT; k++) begin
                q_hit_a = q_hit_a | (v_q[p][k] && a_q[p][k] == q_addr_a);
                q_hit_b = q_hit_b | (v_q[p][k] && a_q[p][k] == q_addr_b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '{default: '0};
            a_q    <= '{default: '0};
            d_q    <= '{default: '0};
            coll_q <= 1'b0;
            waw_q  <= 1'b0;
        end else begin
            v_q    <= v_d;
            a_q    <= a_d;
            d_q    <= d_d;
            coll_q <= coll_d;
            waw_q  <= waw_d;
        end
    end

    // On a same-address collision the odd pipe wins the register file.
    assign rt_we_e   = v_q[0][0] && !waw;
    assign rt_we_o   = v_q[1][0];
    assign rt_addr_e = a_q[0][0];
    assign rt_addr_o = a_q[1][0];
    assign rt_data_e = d_q[0][0];
    assign rt_data_o = d_q[1][0];
    assign coll_err  = coll_q;
    assign waw_err   = waw_q;
endmodule

// File: tb/tb_spu_writeback.sv
// tb_spu_writeback: directed scenarios plus a randomized run against a retire-cycle schedule model
module tb_spu_writeback;
    localparam int DW = 128;
    localparam int AW = 7;
    localparam int ML = 7;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic          in_valid_e, in_valid_o;
    logic [AW-1:0] in_addr_e, in_addr_o, q_addr_a, q_addr_b;
    logic [DW-1:0] in_data_e, in_data_o;
    logic [2:0]    in_lat_e, in_lat_o;
    logic          q_hit_a, q_hit_b, rt_we_e, rt_we_o, coll_err, waw_err;
    logic [AW-1:0] rt_addr_e, rt_addr_o;
    logic [DW-1:0] rt_data_e, rt_data_o;

    int cmp = 0;
    int errs = 0;

    // Model: per pipe, what retires in absolute cycle c lives at index c%16.
    logic          mv [2][16];
    logic [AW-1:0] ma [2][16];
    logic [DW-1:0] md [2][16];
    logic          m_coll, m_waw;
    int            t;

    always #5 clk = ~clk;

    spu_writeback #(.DATA_W(DW), .ADDR_W(AW), .MAX_LAT(ML)) dut (
        .clk(clk), .rst(rst),
        .in_valid_e(in_valid_e), .in_valid_o(in_valid_o),
        .in_addr_e(in_addr_e), .in_addr_o(in_addr_o),
        .in_data_e(in_data_e), .in_data_o(in_data_o),
        .in_lat_e(in_lat_e), .in_lat_o(in_lat_o),
        .flush(flush), .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
        .q_hit_a(q_hit_a), .q_hit_b(q_hit_b),
        .rt_we_e(rt_we_e), .rt_we_o(rt_we_o),
        .rt_addr_e(rt_addr_e), .rt_addr_o(rt_addr_o),
        .rt_data_e(rt_data_e), .rt_data_o(rt_data_o),
        .coll_err(coll_err), .waw_err(waw_err)
    );

    task automatic idle();
        flush = 0; in_valid_e = 0; in_valid_o = 0;
        in_addr_e = '0; in_addr_o = '0; in_data_e = '0; in_data_o = '0;
        in_lat_e = '0; in_lat_o = '0; q_addr_a = '0; q_addr_b = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; idle(); tick(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        in_valid_e = 1; in_lat_e = 1; in_addr_e = 7'd3; in_data_e = 128'hFF;
        tick(); tick();
        rst = 0; idle();
        @(negedge clk);
        cmp++;
        if ({rt_we_e, rt_we_o, coll_err, waw_err, q_hit_a, q_hit_b} !== 6'b0) begin
            errs++;
            $display("FAIL reset_flags got %b want 000000", {rt_we_e, rt_we_o, coll_err, waw_err, q_hit_a, q_hit_b});
        end
        cmp++;
        if ({rt_addr_e, rt_addr_o, rt_data_e, rt_data_o} !== '0) begin
            errs++;
            $display("FAIL reset_payload got %h %h %h %h want all zero", rt_addr_e, rt_addr_o, rt_data_e, rt_data_o);
        end
        tick();
    endtask

    task automatic test_latency();
        logic [DW-1:0] dat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5;
        do_reset();
        in_valid_e = 1; in_addr_e = 7'd5; in_data_e = dat; in_lat_e = 3'd3; q_addr_a = 7'd5;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            cmp++;
            if (rt_we_e !== (i == 3)) begin
                errs++; $display("FAIL latency_we cycle %0d got %b want %b", i, rt_we_e, i == 3);
            end
            cmp++;
            if (q_hit_a !== (i <= 3)) begin
                errs++; $display("FAIL latency_qhit cycle %0d got %b want %b", i, q_hit_a, i <= 3);
            end
            if (i == 3) begin
                cmp++;
                if (rt_addr_e !== 7'd5 || rt_data_e !== dat) begin
                    errs++; $display("FAIL latency_payload got %0d %h want 5 %h", rt_addr_e, rt_data_e, dat);
                end
            end
            tick();
            in_valid_e = 0;
        end
    endtask

    task automatic test_collision();
        do_reset();
        in_valid_e = 1; in_addr_e = 7'd1; in_data_e = 128'd1; in_lat_e = 3'd4;
        tick();
        in_addr_e = 7'd2; in_data_e = 128'd2; in_lat_e = 3'd3;
        @(negedge clk);
        cmp++;
        if (coll_err !== 1'b0) begin
            errs++; $display("FAIL coll_early got %b want 0", coll_err);
        end
        tick(); idle();
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            cmp++;
            if (rt_we_e !== (i == 4) || (i == 4 && rt_addr_e !== 7'd1)) begin
                errs++; $display("FAIL coll_retire cycle %0d got we %b addr %0d want we %b addr 1", i, rt_we_e, rt_addr_e, i == 4);
            end
            cmp++;
            if (coll_err !== 1'b1) begin
                errs++; $display("FAIL coll_flag cycle %0d got %b want 1", i, coll_err);
            end
            tick();
        end
        do_reset();
        in_valid_e = 1; in_addr_e = 7'd1; in_data_e = 128'd1; in_lat_e = 3'd4;
        tick();
        in_addr_e = 7'd2; in_data_e = 128'd2; in_lat_e = 3'd2;
        tick(); idle();
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            cmp++;
            if (rt_we_e !== (i == 3 || i == 4) || (i == 3 && rt_addr_e !== 7'd2) || (i == 4 && rt_addr_e !== 7'd1)) begin
                errs++; $display("FAIL nocoll_retire cycle %0d got we %b addr %0d", i, rt_we_e, rt_addr_e);
            end
            cmp++;
            if (coll_err !== 1'b0) begin
                errs++; $display("FAIL nocoll_flag cycle %0d got %b want 0", i, coll_err);
            end
            tick();
        end
    endtask

    task automatic test_waw();
        do_reset();
        in_valid_e = 1; in_addr_e = 7'd9; in_data_e = 128'hE0; in_lat_e = 3'd2;
        in_valid_o = 1; in_addr_o = 7'd9; in_data_o = 128'hD0; in_lat_o = 3'd2;
        tick(); idle();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            cmp++;
            if (rt_we_o !== (i == 2) || rt_we_e !== 1'b0) begin
                errs++; $display("FAIL waw_we cycle %0d got e %b o %b want e 0 o %b", i, rt_we_e, rt_we_o, i == 2);
            end
            if (i == 2) begin
                cmp++;
                if (rt_addr_o !== 7'd9 || rt_data_o !== 128'hD0) begin
                    errs++; $display("FAIL waw_payload got %0d %h want 9 d0", rt_addr_o, rt_data_o);
                end
            end
            cmp++;
            if (waw_err !== (i == 3)) begin
                errs++; $display("FAIL waw_flag cycle %0d got %b want %b", i, waw_err, i == 3);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid_o = 1; in_addr_o = 7'd1; in_lat_o = 3'd5; in_data_o = 128'h11;
        tick();
        in_addr_o = 7'd2; in_lat_o = 3'd6;
        tick();
        in_addr_o = 7'd3; in_lat_o = 3'd7;
        tick();
        flush = 1; in_addr_o = 7'd4; in_lat_o = 3'd0; q_addr_a = 7'd1; q_addr_b = 7'd4;
        @(negedge clk);
        cmp++;
        if (q_hit_a !== 1'b1 || q_hit_b !== 1'b0) begin
            errs++; $display("FAIL flush_qhit got a %b b %b want a 1 b 0", q_hit_a, q_hit_b);
        end
        tick(); idle(); q_addr_a = 7'd1;
        for (int i = 4; i <= 12; i++) begin
            @(negedge clk);
            cmp++;
            if (rt_we_o !== 1'b0 || q_hit_a !== 1'b0) begin
                errs++; $display("FAIL flush_stale cycle %0d got we %b hit %b want 0 0", i, rt_we_o, q_hit_a);
            end
            tick();
        end
        @(negedge clk);
        cmp++;
        if (coll_err !== 1'b0) begin
            errs++; $display("FAIL flush_coll got %b want 0", coll_err);
        end
        tick();
    endtask

    task automatic test_illegal_reset();
        do_reset();
        in_valid_e = 1; in_addr_e = 7'd3; in_lat_e = 3'd0;
        in_valid_o = 1; in_addr_o = 7'd6; in_lat_o = 3'd5; in_data_o = 128'h66;
        tick(); idle();
        @(negedge clk);
        cmp++;
        if (coll_err !== 1'b1 || rt_we_e !== 1'b0) begin
            errs++; $display("FAIL illegal_lat got coll %b we %b want 1 0", coll_err, rt_we_e);
        end
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        cmp++;
        if ({rt_we_e, rt_we_o, coll_err, waw_err, rt_addr_o, rt_data_o} !== '0) begin
            errs++; $display("FAIL midreset got we %b%b coll %b waw %b addr %0d data %h want zeros", rt_we_e, rt_we_o, coll_err, waw_err, rt_addr_o, rt_data_o);
        end
        for (int i = 3; i <= 8; i++) begin
            tick();
            @(negedge clk);
            cmp++;
            if (rt_we_o !== 1'b0) begin
                errs++; $display("FAIL midreset_stale cycle %0d got %b want 0", i, rt_we_o);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid_e = i < 6; in_addr_e = AW'(i + 20); in_data_e = DW'(i); in_lat_e = 3'd3;
            @(negedge clk);
            cmp++;
            if (rt_we_e !== (i >= 3 && i < 9) || (i >= 3 && i < 9 && rt_addr_e !== AW'(i + 17))) begin
                errs++; $display("FAIL b2b cycle %0d got we %b addr %0d want we %b addr %0d", i, rt_we_e, rt_addr_e, i >= 3 && i < 9, i + 17);
            end
            tick();
        end
        @(negedge clk);
        cmp++;
        if (coll_err !== 1'b0) begin
            errs++; $display("FAIL b2b_coll got %b want 0", coll_err);
        end
        tick();
    endtask

    task automatic test_random();
        logic          ev, ov, w, ha, hb, v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    l;
        do_reset();
        mv = '{default: '0}; ma = '{default: '0}; md = '{default: '0};
        m_coll = 0; m_waw = 0; t = 0;
        for (int n = 0; n < 4000; n++) begin
            rst   = $urandom_range(0, 59) == 0;
            flush = $urandom_range(0, 39) == 0;
            in_valid_e = $urandom_range(0, 2) != 0;
            in_valid_o = $urandom_range(0, 2) != 0;
            in_addr_e = AW'($urandom_range(0, 7));
            in_addr_o = AW'($urandom_range(0, 7));
            in_data_e = {$urandom, $urandom, $urandom, $urandom};
            in_data_o = {$urandom, $urandom, $urandom, $urandom};
            in_lat_e = ($urandom_range(0, 63) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            in_lat_o = ($urandom_range(0, 63) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            q_addr_a = AW'($urandom_range(0, 7));
            q_addr_b = AW'($urandom_range(0, 7));
            @(negedge clk);
            ev = mv[0][t % 16];
            ov = mv[1][t % 16];
            w  = ev && ov && ma[0][t % 16] == ma[1][t % 16];
            ha = !flush && ((in_valid_e && in_addr_e == q_addr_a) || (in_valid_o && in_addr_o == q_addr_a));
            hb = !flush && ((in_valid_e && in_addr_e == q_addr_b) || (in_valid_o && in_addr_o == q_addr_b));
            for (int p = 0; p < 2; p++)
                for (int j = 0; j < 16; j++) begin
                    ha = ha | (mv[p][j] && ma[p][j] == q_addr_a);
                    hb = hb | (mv[p][j] && ma[p][j] == q_addr_b);
                end
            cmp++;
            if (rt_we_e !== (ev && !w) || rt_we_o !== ov) begin
                errs++; $display("FAIL rand_we t=%0d got e %b o %b want e %b o %b", t, rt_we_e, rt_we_o, ev && !w, ov);
            end
            if (ev && !w) begin
                cmp++;
                if (rt_addr_e !== ma[0][t % 16] || rt_data_e !== md[0][t % 16]) begin
                    errs++; $display("FAIL rand_even t=%0d got %0d %h want %0d %h", t, rt_addr_e, rt_data_e, ma[0][t % 16], md[0][t % 16]);
                end
            end
            if (ov) begin
                cmp++;
                if (rt_addr_o !== ma[1][t % 16] || rt_data_o !== md[1][t % 16]) begin
                    errs++; $display("FAIL rand_odd t=%0d got %0d %h want %0d %h", t, rt_addr_o, rt_data_o, ma[1][t % 16], md[1][t % 16]);
                end
            end
            cmp++;
            if (coll_err !== m_coll || waw_err !== m_waw) begin
                errs++; $display("FAIL rand_flags t=%0d got coll %b waw %b want %b %b", t, coll_err, waw_err, m_coll, m_waw);
            end
            cmp++;
            if (q_hit_a !== ha || q_hit_b !== hb) begin
                errs++; $display("FAIL rand_qhit t=%0d got a %b b %b want %b %b", t, q_hit_a, q_hit_b, ha, hb);
            end
            @(posedge clk);
            if (rst) begin
                mv = '{default: '0}; m_coll = 0; m_waw = 0;
            end else begin
                m_waw = m_waw | w;
                mv[0][t % 16] = 0;
                mv[1][t % 16] = 0;
                if (flush) mv = '{default: '0};
                else
                    for (int p = 0; p < 2; p++) begin
                        v = p == 0 ? in_valid_e : in_valid_o;
                        a = p == 0 ? in_addr_e : in_addr_o;
                        d = p == 0 ? in_data_e : in_data_o;
                        l = p == 0 ? in_lat_e : in_lat_o;
                        if (v) begin
                            if (l == 0 || int'(l) > ML || mv[p][(t + int'(l)) % 16]) m_coll = 1;
                            else begin
                                mv[p][(t + int'(l)) % 16] = 1;
                                ma[p][(t + int'(l)) % 16] = a;
                                md[p][(t + int'(l)) % 16] = d;
                            end
                        end
                    end
            end
            t++;
            #1;
        end
        rst = 0; idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_latency();
        test_collision();
        test_waw();
        test_flush();
        test_illegal_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
